uart_cmd_parser: RTL and testbench

Frame-level command sequencer that sits directly behind the UART byte receiver. It consumes the receiver's byte strobe and framing-error flag, hunts for a sync byte, and parses each frame as SYNC, CMD, LEN, PAYLOAD[LEN], CHK. Valid commands are presented to the command executor on a valid/ready handshake, with the payload held in an internal buffer that the executor reads by address.

---
 rtl/uart_cmd_parser_if.sv | 25 ++
 rtl/uart_cmd_parser.sv | 205 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// Command/payload handshake between uart_cmd_parser (master) and the command
// executor (slave). The executor reads the payload buffer by address.
interface uart_cmd_parser_if #(
   parameter int unsigned MAX_LEN = 16
);
   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [7:0]    cmd_code;
   logic [LW-1:0] cmd_len;
   logic [AW-1:0] pld_addr;
   logic [7:0]    pld_data;

   modport master (
      output cmd_valid, cmd_code, cmd_len, pld_data,
      input  cmd_ready, pld_addr
   );

   modport slave (
      input  cmd_valid, cmd_code, cmd_len, pld_data,
      output cmd_ready, pld_addr
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frame-level command parser behind a UART byte receiver.
// Frame: SYNC, CMD, LEN, PAYLOAD[LEN], CHK where CHK = XOR(CMD, LEN, PAYLOAD).
// A valid command is held on the cmd interface until the executor accepts it.
// Optional inter-byte timeout: define INTERBYTE_TIMEOUT_EN (otherwise
// err_timeout is tied low and the parser waits indefinitely).
module uart_cmd_parser #(
   parameter int unsigned MAX_LEN     = 16,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_done,
   input  logic                     framing_err,
   uart_cmd_parser_if.master        cmd,
   output logic                     busy,
   output logic                     err_chk,
   output logic                     err_len,
   output logic                     err_frame,
   output logic                     ovr_drop,
   output logic                     err_timeout
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      StHunt,
      StCmd,
      StLen,
      StPayload,
      StChk,
      StHold
   } state_e;

   state_e        state_q;
   logic          busy_q;
   logic          cmd_valid_q;
   logic [7:0]    cmd_code_q;
   logic [LW-1:0] cmd_len_q;
   logic [LW-1:0] idx_q;
   logic [7:0]    csum_q;
   logic          err_chk_q;
   logic          err_len_q;
   logic          err_frame_q;
   logic          ovr_drop_q;
   logic [7:0]    pld_data_q;
   logic [7:0]    mem_q [2**AW];
   logic          tmo_hit;

`ifdef INTERBYTE_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] tmo_cnt_q;
   logic          err_timeout_q;
   logic          in_frame;

   assign in_frame = (state_q == StCmd) || (state_q == StLen) ||
                     (state_q == StPayload) || (state_q == StChk);
   // A strobe in the same cycle as expiry counts as arriving in time.
   assign tmo_hit  = in_frame && !rx_done && !framing_err &&
                     (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

   // Inter-byte idle counter; only runs while a frame is partially received.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q     <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         err_timeout_q <= tmo_hit;
         if (!in_frame || rx_done || tmo_hit) begin
            tmo_cnt_q <= '0;
         end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
         end
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign tmo_hit     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Frame parser: state, latched command, running checksum and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHunt;
         busy_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= 8'h00;
         cmd_len_q   <= '0;
         idx_q       <= '0;
         csum_q      <= 8'h00;
         err_chk_q   <= 1'b0;
         err_len_q   <= 1'b0;
         err_frame_q <= 1'b0;
         ovr_drop_q  <= 1'b0;
      end else begin
         err_chk_q   <= 1'b0;
         err_len_q   <= 1'b0;
         err_frame_q <= 1'b0;
         ovr_drop_q  <= 1'b0;

         if (framing_err) begin
            // Line error beats a simultaneous byte; a pending command survives it.
            err_frame_q <= 1'b1;
            if (state_q != StHold) begin
               state_q <= StHunt;
               busy_q  <= 1'b0;
            end
         end else if (tmo_hit) begin
            state_q <= StHunt;
            busy_q  <= 1'b0;
         end else if (rx_done) begin
            unique case (state_q)
               StHunt: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_q <= StCmd;
                     busy_q  <= 1'b1;
                  end
               end
               StCmd: begin
                  cmd_code_q <= rx_data;
                  csum_q     <= rx_data;
                  state_q    <= StLen;
               end
               StLen: begin
                  if (32'(rx_data) > MAX_LEN) begin
                     err_len_q <= 1'b1;
                     state_q   <= StHunt;
                     busy_q    <= 1'b0;
                  end else begin
                     cmd_len_q <= LW'(rx_data);
                     csum_q    <= csum_q ^ rx_data;
                     idx_q     <= '0;
                     state_q   <= (rx_data == 8'h00) ? StChk : StPayload;
                  end
               end
               StPayload: begin
                  csum_q <= csum_q ^ rx_data;
                  idx_q  <= idx_q + LW'(1);
                  if (idx_q == cmd_len_q - LW'(1)) begin
                     state_q <= StChk;
                  end
               end
               StChk: begin
                  if (rx_data == csum_q) begin
                     cmd_valid_q <= 1'b1;
                     state_q     <= StHold;
                  end else begin
                     err_chk_q <= 1'b1;
                     state_q   <= StHunt;
                     busy_q    <= 1'b0;
                  end
               end
               StHold: begin
                  // Executor has not taken the last command; this byte is lost.
                  ovr_drop_q <= 1'b1;
               end
               default: begin
                  state_q <= StHunt;
                  busy_q  <= 1'b0;
               end
            endcase
         end

         if ((state_q == StHold) && cmd_valid_q && cmd.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= StHunt;
            busy_q      <= 1'b0;
         end
      end
   end

   // Payload buffer write; contents need no reset.
   always_ff @(posedge clk) begin
      if (rx_done && !framing_err && (state_q == StPayload)) begin
         mem_q[idx_q[AW-1:0]] <= rx_data;
      end
   end

   // Registered payload read port; out-of-range addresses read as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pld_data_q <= 8'h00;
      end else if (32'(cmd.pld_addr) < MAX_LEN) begin
         pld_data_q <= mem_q[cmd.pld_addr];
      end else begin
         pld_data_q <= 8'h00;
      end
   end

   assign cmd.cmd_valid = cmd_valid_q;
   assign cmd.cmd_code  = cmd_code_q;
   assign cmd.cmd_len   = cmd_len_q;
   assign cmd.pld_data  = pld_data_q;
   assign busy          = busy_q;
   assign err_chk       = err_chk_q;
   assign err_len       = err_len_q;
   assign err_frame     = err_frame_q;
   assign ovr_drop      = ovr_drop_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: the stimulus feeds a byte-level
// reference model that queues expected events; a negedge monitor pops and
// compares them as the DUT raises pulses or presents commands.
module tb_uart_cmd_parser;

   localparam int unsigned MAXL = 16;
   localparam int unsigned TMO  = 100;
   localparam logic [7:0]  SYNC = 8'hA5;

   typedef enum int {EvCmd, EvChk, EvLen, EvFrame, EvOvr, EvTmo} ev_kind_e;

   typedef struct {
      ev_kind_e   kind;
      int         due;
      logic [7:0] code;
      int         len;
      logic [7:0] pl [MAXL];
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       framing_err = 1'b0;
   logic       busy, err_chk, err_len, err_frame, ovr_drop, err_timeout;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  last_cyc = 0;
   bit  allow_ready = 1'b1;

   // Reference model state
   ev_t        exp_q[$];
   logic [7:0] fr[$];
   bit         m_in_frame = 1'b0;
   bit         m_pending = 1'b0;

   // Monitor state
   ev_t cur;
   bit  have_cmd = 1'b0;
   int  ph = 0;
   int  rd_i = 0;

   uart_cmd_parser_if #(.MAX_LEN(MAXL)) cif ();

   uart_cmd_parser #(
      .MAX_LEN    (MAXL),
      .SYNC_BYTE  (SYNC),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .framing_err(framing_err),
      .cmd        (cif),
      .busy       (busy),
      .err_chk    (err_chk),
      .err_len    (err_len),
      .err_frame  (err_frame),
      .ovr_drop   (ovr_drop),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input ev_kind_e k, input int due);
      ev_t e;
      e.kind = k;
      e.due  = due;
      e.code = 8'h00;
      e.len  = 0;
      for (int i = 0; i < MAXL; i++) e.pl[i] = 8'h00;
      exp_q.push_back(e);
   endtask

   // Byte-level behavioural model: collects a frame and judges it once complete.
   task automatic model(input logic [7:0] b, input bit ferr, input bit strobe);
      logic [7:0] x;
      ev_t e;
      if (ferr) begin
         push_ev(EvFrame, cyc);
         if (!m_pending) begin
            m_in_frame = 1'b0;
            fr.delete();
         end
         return;
      end
      if (!strobe) return;
      if (m_pending) begin
         push_ev(EvOvr, cyc);
         return;
      end
      if (!m_in_frame) begin
         if (b == SYNC) begin
            m_in_frame = 1'b1;
            fr.delete();
         end
         return;
      end
      fr.push_back(b);
      if (fr.size() == 2 && fr[1] > MAXL) begin
         push_ev(EvLen, cyc);
         m_in_frame = 1'b0;
         return;
      end
      if (fr.size() >= 2 && fr.size() == fr[1] + 3) begin
         x = 8'h00;
         for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
         if (x == fr[fr.size()-1]) begin
            e.kind = EvCmd;
            e.due  = cyc;
            e.code = fr[0];
            e.len  = int'(fr[1]);
            for (int i = 0; i < MAXL; i++) e.pl[i] = (i < e.len) ? fr[2+i] : 8'h00;
            exp_q.push_back(e);
            m_pending = 1'b1;
         end else begin
            push_ev(EvChk, cyc);
         end
         m_in_frame = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit ferr, input bit strobe);
      int n;
      n = 0;
      while (m_pending && allow_ready && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (n >= 500) chk("wait_accept_timeout", 1, 0);
      @(posedge clk);
      #1;
      rx_data     = b;
      rx_done     = strobe;
      framing_err = ferr;
      @(posedge clk);
      #1;
      rx_done     = 1'b0;
      framing_err = 1'b0;
      last_cyc    = cyc;
      model(b, ferr, strobe);
      repeat ($urandom_range(0, 3)) @(posedge clk);
   endtask

   task automatic send_q(input logic [7:0] q[$]);
      foreach (q[i]) send(q[i], 1'b0, 1'b1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_pending || exp_q.size() != 0) && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk("wait_idle_timeout", (n >= 1000), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_cmd_valid"}, cif.cmd_valid, 0);
      chk({tag, "_cmd_code"}, cif.cmd_code, 0);
      chk({tag, "_cmd_len"}, cif.cmd_len, 0);
      chk({tag, "_pld_data"}, cif.pld_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err_chk"}, err_chk, 0);
      chk({tag, "_err_len"}, err_len, 0);
      chk({tag, "_err_frame"}, err_frame, 0);
      chk({tag, "_ovr_drop"}, ovr_drop, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   task automatic take(input ev_kind_e k, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
         return;
      end
      e = exp_q.pop_front();
      chk({name, "_kind"}, 32'(k), 32'(e.kind));
      chk({name, "_cycle"}, cyc, e.due);
      if (k == EvCmd) begin
         chk("cmd_code", cif.cmd_code, e.code);
         chk("cmd_len", cif.cmd_len, e.len);
         cur = e;
      end
   endtask

   // Monitor/executor: pops expected events, reads the payload, then accepts.
   always @(negedge clk) begin
      if (rst) begin
         cif.cmd_ready = 1'b0;
         cif.pld_addr  = '0;
         have_cmd      = 1'b0;
         ph            = 0;
      end else begin
         if (have_cmd) begin
            if (ph < 3) begin
               chk("hold_cmd_valid", cif.cmd_valid, 1);
               chk("hold_cmd_code", cif.cmd_code, cur.code);
               chk("hold_cmd_len", cif.cmd_len, cur.len);
               chk("hold_busy", busy, 1);
            end
            case (ph)
               0: if (allow_ready) begin
                  rd_i         = 0;
                  cif.pld_addr = '0;
                  ph           = (cur.len == 0) ? 2 : 1;
               end
               1: begin
                  chk("pld_data", cif.pld_data, cur.pl[rd_i]);
                  rd_i++;
                  if (rd_i == cur.len) ph = 2;
                  else cif.pld_addr = 4'(rd_i);
               end
               2: if ($urandom_range(0, 1) == 1) begin
                  cif.cmd_ready = 1'b1;
                  ph            = 3;
               end
               default: begin
                  cif.cmd_ready = 1'b0;
                  chk("accept_cmd_valid_low", cif.cmd_valid, 0);
                  chk("accept_busy_low", busy, 0);
                  have_cmd  = 1'b0;
                  m_pending = 1'b0;
                  ph        = 0;
               end
            endcase
         end
         if (err_chk)     take(EvChk, "err_chk");
         if (err_len)     take(EvLen, "err_len");
         if (err_frame)   take(EvFrame, "err_frame");
         if (ovr_drop)    take(EvOvr, "ovr_drop");
         if (err_timeout) take(EvTmo, "err_timeout");
         if (cif.cmd_valid && !have_cmd) begin
            take(EvCmd, "cmd_valid");
            have_cmd = 1'b1;
            ph       = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] f[$];
      logic [7:0] x;
      int len;
      int k;

      // Reset state
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Basic frame held with ready low, then accepted
      allow_ready = 1'b0;
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      repeat (5) @(posedge clk);
      allow_ready = 1'b1;
      wait_idle();

      // Garbage before a zero-length frame
      send_q('{8'h3C, 8'h7E, 8'hA5, 8'h05, 8'h00, 8'h05});
      wait_idle();

      // Bad checksum, then a good frame
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20});
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      wait_idle();

      // LEN too large; framing error mid-frame; recovery
      send_q('{8'hA5, 8'h10, 8'h11});
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11});
      send(8'h00, 1'b1, 1'b0);
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      wait_idle();

      // Overrun while a command is pending, plus a line error in HOLD
      allow_ready = 1'b0;
      send_q('{8'hA5, 8'h33, 8'h03, 8'h01, 8'h02, 8'h03, 8'h30});
      for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0, 1'b1);
      send(8'h00, 1'b1, 1'b0);
      allow_ready = 1'b1;
      wait_idle();

      // Simultaneous byte and framing error in PAYLOAD
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11});
      send(8'h22, 1'b1, 1'b1);
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      wait_idle();

      // Inter-byte timeout behaviour
      send_q('{8'hA5, 8'h10});
`ifdef INTERBYTE_TIMEOUT_EN
      push_ev(EvTmo, last_cyc + TMO);
      m_in_frame = 1'b0;
      repeat (TMO + 20) @(posedge clk);
      @(negedge clk);
      chk("timeout_busy", busy, 0);
`else
      repeat (TMO + 20) @(posedge clk);
      @(negedge clk);
      chk("no_timeout_busy", busy, 1);
      send(8'h00, 1'b1, 1'b0);
`endif
      wait_idle();

      // Reset mid-frame aborts without pulses
      send_q('{8'hA5, 8'h10, 8'h02});
      @(posedge clk);
      #1 rst = 1'b1;
      m_in_frame = 1'b0;
      fr.delete();
      check_reset_outputs("midreset");
      @(posedge clk);
      #1 rst = 1'b0;
      send_q('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
      wait_idle();

      // Randomised traffic
      for (int it = 0; it < 40; it++) begin
         k = $urandom_range(0, 9);
         f.delete();
         len = $urandom_range(0, MAXL);
         f.push_back(SYNC);
         f.push_back(8'($urandom));
         f.push_back(8'(len));
         x = f[1] ^ f[2];
         for (int i = 0; i < len; i++) begin
            f.push_back(8'($urandom));
            x = x ^ f[f.size()-1];
         end
         if (k <= 1) begin
            repeat ($urandom_range(1, 3)) send(8'($urandom), 1'b0, 1'b1);
         end else if (k <= 6) begin
            f.push_back(x);
            send_q(f);
         end else if (k == 7) begin
            f.push_back(x ^ 8'($urandom_range(1, 255)));
            send_q(f);
         end else if (k == 8) begin
            f[2] = 8'($urandom_range(MAXL + 1, 255));
            send_q(f[0:2]);
         end else begin
            f.push_back(x);
            len = $urandom_range(1, f.size() - 1);
            for (int i = 0; i < len; i++) send(f[i], 1'b0, 1'b1);
            send(f[len], 1'b1, 1'($urandom_range(0, 1)));
         end
      end

      // Return to HUNT and drain
      send(8'h00, 1'b1, 1'b0);
      wait_idle();
      repeat (10) @(posedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_no_pending_cmd", have_cmd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
